// File: rtl/q2_panel_ctrl.sv
// q2_panel_ctrl: front-panel switch synchroniser/debouncer and deposit / PC-increment / run-halt sequencer.
// Optional build macro Q2_PANEL_STEP_EN adds step_sw and a single-instruction STEPPING state.
module q2_panel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    input  logic        dep_sw,
    input  logic        incp_sw,
    input  logic        start_sw,
    input  logic        stop_sw,
`ifdef Q2_PANEL_STEP_EN
    input  logic        step_sw,
`endif
    input  logic        cpu_fetch,
    input  logic        cpu_halt,
    input  logic        mem_wr_ack,
    output logic        mem_wr_req,
    output logic [11:0] mem_wdata,
    output logic        pc_inc,
    output logic        cpu_en,
    output logic        run
);

    localparam int IDX_DEP   = 0;
    localparam int IDX_INCP  = 1;
    localparam int IDX_START = 2;
    localparam int IDX_STOP  = 3;
`ifdef Q2_PANEL_STEP_EN
    localparam int IDX_STEP  = 4;
    localparam int NSW       = 5;
`else
    localparam int NSW       = 4;
`endif

    typedef enum logic [2:0] {
        S_HALT,
        S_DEP_WR,
        S_DEP_INC,
        S_INCP,
        S_RUN,
        S_STOPPING
`ifdef Q2_PANEL_STEP_EN
        , S_STEPPING
`endif
    } state_t;

    logic [NSW-1:0] raw_sw;
    logic [NSW-1:0] deb_lvl;
    logic [NSW-1:0] deb_dly_q;
    logic [NSW-1:0] press;
    logic [11:0]    sw_s1_q;
    logic [11:0]    sw_s2_q;

`ifdef Q2_PANEL_STEP_EN
    assign raw_sw = {step_sw, stop_sw, start_sw, incp_sw, dep_sw};
`else
    assign raw_sw = {stop_sw, start_sw, incp_sw, dep_sw};
`endif

    // Per switch: 2-FF synchroniser, then a counter that must see the new level
    // for DEBOUNCE_CYCLES consecutive cycles before the debounced level follows.
    generate
        for (genvar gi = 0; gi < NSW; gi++) begin : g_deb
            logic             sync1_q;
            logic             sync2_q;
            logic             lvl_q;
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    lvl_q   <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_sw[gi];
                    sync2_q <= sync1_q;
                    if (sync2_q == lvl_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        lvl_q <= sync2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign deb_lvl[gi] = lvl_q;
        end
    endgenerate

    assign press = deb_lvl & ~deb_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_dly_q <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
        end else begin
            deb_dly_q <= deb_lvl;
            sw_s1_q   <= sw;
            sw_s2_q   <= sw_s1_q;
        end
    end

    logic   stop_lvl;
    logic   start_ev;
    logic   dep_ev;
    logic   incp_ev;
    logic   stop_ev;
`ifdef Q2_PANEL_STEP_EN
    logic   step_ev;
    logic   step_seen_q;
    assign step_ev = press[IDX_STEP];
`endif

    assign stop_lvl = deb_lvl[IDX_STOP];
    assign stop_ev  = press[IDX_STOP];
    assign start_ev = press[IDX_START];
    assign dep_ev   = press[IDX_DEP];
    assign incp_ev  = press[IDX_INCP];

    state_t      state_q;
    logic        mem_wr_req_q;
    logic [11:0] mem_wdata_q;
    logic        pc_inc_q;
    logic        cpu_en_q;
    logic        run_q;

    // Outputs are assigned together with each state transition so they always
    // reflect the state being entered; presses outside HALT simply fall through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HALT;
            mem_wr_req_q <= 1'b0;
            mem_wdata_q  <= '0;
            pc_inc_q     <= 1'b0;
            cpu_en_q     <= 1'b0;
            run_q        <= 1'b0;
`ifdef Q2_PANEL_STEP_EN
            step_seen_q  <= 1'b0;
`endif
        end else begin
            pc_inc_q <= 1'b0;
            case (state_q)
                S_HALT: begin
                    if (start_ev && !stop_lvl) begin
                        state_q  <= S_RUN;
                        run_q    <= 1'b1;
                        cpu_en_q <= 1'b1;
`ifdef Q2_PANEL_STEP_EN
                    end else if (step_ev) begin
                        state_q     <= S_STEPPING;
                        cpu_en_q    <= 1'b1;
                        step_seen_q <= 1'b0;
`endif
                    end else if (dep_ev) begin
                        state_q      <= S_DEP_WR;
                        mem_wr_req_q <= 1'b1;
                        mem_wdata_q  <= sw_s2_q;
                    end else if (incp_ev) begin
                        state_q  <= S_INCP;
                        pc_inc_q <= 1'b1;
                    end
                end
                S_DEP_WR: begin
                    if (mem_wr_ack) begin
                        state_q      <= S_DEP_INC;
                        mem_wr_req_q <= 1'b0;
                        pc_inc_q     <= 1'b1;
                    end
                end
                S_DEP_INC, S_INCP: begin
                    state_q <= S_HALT;
                end
                S_RUN: begin
                    if (cpu_halt) begin
                        state_q  <= S_HALT;
                        run_q    <= 1'b0;
                        cpu_en_q <= 1'b0;
                    end else if (stop_lvl || stop_ev) begin
                        state_q <= S_STOPPING;
                    end
                end
                S_STOPPING: begin
                    if (cpu_fetch || cpu_halt) begin
                        state_q  <= S_HALT;
                        run_q    <= 1'b0;
                        cpu_en_q <= 1'b0;
                    end
                end
`ifdef Q2_PANEL_STEP_EN
                // The first fetch begins the stepped instruction; the next one ends it.
                S_STEPPING: begin
                    if (cpu_halt || (cpu_fetch && step_seen_q)) begin
                        state_q  <= S_HALT;
                        cpu_en_q <= 1'b0;
                    end else if (cpu_fetch) begin
                        step_seen_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q      <= S_HALT;
                    mem_wr_req_q <= 1'b0;
                    run_q        <= 1'b0;
                    cpu_en_q     <= 1'b0;
                end
            endcase
        end
    end

    assign mem_wr_req = mem_wr_req_q;
    assign mem_wdata  = mem_wdata_q;
    assign pc_inc     = pc_inc_q;
    assign cpu_en     = cpu_en_q;
    assign run        = run_q;

endmodule

// File: tb/tb_q2_panel_ctrl.sv
// Randomised scoreboard bench for q2_panel_ctrl: each panel operation queues the datapath
// events it must cause (write, PC increment, run on/off); a monitor matches observed events.
module tb_q2_panel_ctrl;

    localparam int N      = 4;
    localparam int SETTLE = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sw;
    logic        dep_sw, incp_sw, start_sw, stop_sw;
    logic        cpu_fetch, cpu_halt, mem_wr_ack;
    logic        mem_wr_req;
    logic [11:0] mem_wdata;
    logic        pc_inc, cpu_en, run;

    always #5 clk = ~clk;

    q2_panel_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .dep_sw(dep_sw), .incp_sw(incp_sw), .start_sw(start_sw), .stop_sw(stop_sw),
`ifdef Q2_PANEL_STEP_EN
        .step_sw(1'b0),
`endif
        .cpu_fetch(cpu_fetch), .cpu_halt(cpu_halt), .mem_wr_ack(mem_wr_ack),
        .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata), .pc_inc(pc_inc),
        .cpu_en(cpu_en), .run(run)
    );

    typedef enum logic [1:0] {EV_WR, EV_INC, EV_RUN_ON, EV_RUN_OFF} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic [11:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input int which, input logic v);
        case (which)
            0: dep_sw   = v;
            1: incp_sw  = v;
            2: start_sw = v;
            3: stop_sw  = v;
            default: ;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_sw(which, 1'b1);
        tick(hold);
        set_sw(which, 1'b0);
        tick(SETTLE);
    endtask

    task automatic pulse_fetch();
        cpu_fetch = 1'b1; tick(1); cpu_fetch = 1'b0;
    endtask

    task automatic pulse_halt();
        cpu_halt = 1'b1; tick(1); cpu_halt = 1'b0;
    endtask

    // Monitor: one observed datapath event per line, matched against the queue.
    logic wr_prev = 1'b0, inc_prev = 1'b0, run_prev = 1'b0;

    task automatic observe(input ev_kind_t k, input logic [11:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected none (t=%0t)", k, d, $time);
        end else begin
            e = exp_q.pop_front();
            $display("event kind=%0d data=%03h (t=%0t)", k, d, $time);
            chk("event_kind", 32'(k), 32'(e.kind));
            if (e.kind == EV_WR && k == EV_WR) chk("event_wdata", 32'(d), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            wr_prev  <= 1'b0;
            inc_prev <= 1'b0;
            run_prev <= 1'b0;
        end else begin
            if (mem_wr_req && !wr_prev) observe(EV_WR, mem_wdata);
            if (pc_inc && !inc_prev)    observe(EV_INC, 12'h0);
            if (pc_inc && inc_prev) begin
                n_vec++;
                n_err++;
                $display("FAIL pc_inc_width: got 2+ cycles expected 1 (t=%0t)", $time);
            end
            if (run && !run_prev) observe(EV_RUN_ON, 12'h0);
            if (!run && run_prev) observe(EV_RUN_OFF, 12'h0);
            chk("cpu_en_eq_run", 32'(cpu_en), 32'(run));
            wr_prev  <= mem_wr_req;
            inc_prev <= pc_inc;
            run_prev <= run;
        end
    end

    task automatic do_deposit(input logic [11:0] d, input int ack_dly);
        int lat;
        bit seen;
        sw = d;
        exp_q.push_back('{EV_WR, d});
        exp_q.push_back('{EV_INC, 12'h0});
        dep_sw = 1'b1;
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (mem_wr_req) begin
                seen = 1'b1;
                lat = k;
            end
        end
        chk("dep_latency", 32'(lat), 32'(2 + N + 1));
        sw = 12'($urandom);
        tick(ack_dly);
        chk("wr_req_held", 32'(mem_wr_req), 32'd1);
        chk("wdata_held", 32'(mem_wdata), 32'(d));
        chk("no_inc_before_ack", 32'(pc_inc), 32'd0);
        mem_wr_ack = 1'b1;
        tick(1);
        mem_wr_ack = 1'b0;
        chk("pc_inc_after_ack", 32'(pc_inc), 32'd1);
        chk("wr_req_dropped", 32'(mem_wr_req), 32'd0);
        tick(1);
        chk("pc_inc_one_cycle", 32'(pc_inc), 32'd0);
        dep_sw = 1'b0;
        tick(SETTLE);
        chk("halt_run_off", 32'(run), 32'd0);
    endtask

    task automatic do_incp();
        exp_q.push_back('{EV_INC, 12'h0});
        press(1, 10);
        chk("incp_run_off", 32'(run), 32'd0);
    endtask

    task automatic do_glitch(input int which, input int len);
        set_sw(which, 1'b1);
        tick(len);
        set_sw(which, 1'b0);
        tick(SETTLE);
        chk("glitch_no_wr", 32'(mem_wr_req), 32'd0);
        chk("glitch_no_run", 32'(run), 32'd0);
    endtask

    task automatic do_run(input int mode);
        exp_q.push_back('{EV_RUN_ON, 12'h0});
        press(2, $urandom_range(N + 4, N + 8));
        chk("run_on", 32'(run), 32'd1);
        chk("cpu_en_on", 32'(cpu_en), 32'd1);
        repeat ($urandom_range(1, 4)) begin
            pulse_fetch();
            tick($urandom_range(0, 3));
        end
        chk("run_after_fetches", 32'(run), 32'd1);
        case (mode)
            0: begin
                press(0, 10);
                chk("dep_in_run_no_wr", 32'(mem_wr_req), 32'd0);
                exp_q.push_back('{EV_RUN_OFF, 12'h0});
                pulse_halt();
                chk("halt_run_off", 32'(run), 32'd0);
                chk("halt_cpu_en_off", 32'(cpu_en), 32'd0);
                tick(3);
                chk("no_wr_after_halt", 32'(mem_wr_req), 32'd0);
            end
            1: begin
                stop_sw = 1'b1;
                tick(15);
                chk("stopping_run_held", 32'(run), 32'd1);
                exp_q.push_back('{EV_RUN_OFF, 12'h0});
                pulse_fetch();
                chk("stop_run_off", 32'(run), 32'd0);
                chk("stop_cpu_en_off", 32'(cpu_en), 32'd0);
                press(2, 10);
                chk("start_blocked_by_stop", 32'(run), 32'd0);
                stop_sw = 1'b0;
                tick(SETTLE);
            end
            default: begin
                stop_sw = 1'b1;
                tick(15);
                exp_q.push_back('{EV_RUN_OFF, 12'h0});
                pulse_halt();
                chk("stopping_halt_run_off", 32'(run), 32'd0);
                stop_sw = 1'b0;
                tick(SETTLE);
            end
        endcase
    endtask

    initial begin
        rst = 1'b1;
        sw = '0;
        dep_sw = 1'b0; incp_sw = 1'b0; start_sw = 1'b0; stop_sw = 1'b0;
        cpu_fetch = 1'b0; cpu_halt = 1'b0; mem_wr_ack = 1'b0;
        tick(3);
        chk("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_pc_inc", 32'(pc_inc), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        rst = 1'b0;
        tick(2);

        do_deposit(12'h5A5, 3);
        do_glitch(0, 3);
        repeat (3) do_incp();
        do_run(1);
        do_run(0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: do_deposit(12'($urandom), $urandom_range(0, 5));
                1: do_incp();
                2: do_glitch($urandom_range(0, 2), $urandom_range(1, N - 1));
                3: do_run(0);
                4: do_run(1);
                default: do_run(2);
            endcase
        end

        // Reset in the middle of a withheld-ack deposit.
        sw = 12'h3C7;
        exp_q.push_back('{EV_WR, 12'h3C7});
        dep_sw = 1'b1;
        for (int k = 0; k < 40 && !mem_wr_req; k++) @(negedge clk);
        chk("mid_dep_wr_req", 32'(mem_wr_req), 32'd1);
        tick(3);
        #2 rst = 1'b1;
        #1 chk("rst_async_wr_drop", 32'(mem_wr_req), 32'd0);
        dep_sw = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(20);
        chk("post_rst_pc_inc", 32'(pc_inc), 32'd0);
        chk("post_rst_run", 32'(run), 32'd0);
        chk("post_rst_wr_req", 32'(mem_wr_req), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/q2_panel_ctrl.md
Name: q2_panel_ctrl

Overview:
Front-panel sequencer for the q2 12-bit machine. Debounces the momentary panel switches (deposit, increment-PC, start, stop) and turns presses into datapath operations: memory deposit at the current PC, PC increment, and run/halt control of the CPU core. Sits between the raw switch pins and the CPU/memory datapath; it owns the memory write port whenever the CPU is halted.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required before a debounced switch level changes
CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sw  input  12  data switches (raw, asynchronous)
dep_sw  input  1  deposit switch (raw, momentary)
incp_sw  input  1  increment-PC switch (raw, momentary)
start_sw  input  1  start switch (raw, momentary)
stop_sw  input  1  stop switch (raw, level)
cpu_fetch  input  1  one-cycle pulse from CPU at each instruction boundary
cpu_halt  input  1  one-cycle pulse from CPU when HLT executes
mem_wr_ack  input  1  memory accepted the write
mem_wr_req  output  1  panel memory write request, address = current PC
mem_wdata  output  12  data for panel write
pc_inc  output  1  one-cycle PC increment strobe
cpu_en  output  1  CPU may advance
run  output  1  run lamp / machine running

Behaviour:
- Reset (async): state HALT; all outputs 0; debounced levels 0; counters 0; synchronisers cleared.
- Each switch: 2-FF synchroniser, then debounce: counter reloads whenever synced level equals debounced level; debounced level takes the synced value after DEBOUNCE_CYCLES consecutive differing cycles. sw[11:0] is synchronised only (no debounce).
- Press event = debounced rising edge, one cycle wide. stop uses debounced level (stop_lvl) plus its press event.
- Total latency raw press -> event: 2 + DEBOUNCE_CYCLES + 1 cycles.
- States: HALT, DEP_WR, DEP_INC, INCP, RUN, STOPPING.
- HALT: run=0, cpu_en=0. Same-cycle priority: start (only if stop_lvl=0) > dep > incp.
  start -> RUN. dep -> DEP_WR, mem_wdata latched from synced sw that cycle. incp -> INCP.
- DEP_WR: mem_wr_req=1 held, mem_wdata stable, until mem_wr_ack sampled high -> DEP_INC. No timeout.
- DEP_INC: pc_inc=1 for exactly one cycle -> HALT.
- INCP: pc_inc=1 for exactly one cycle -> HALT.
- RUN: run=1, cpu_en=1. cpu_halt -> HALT (cpu_en 0 next cycle). stop_lvl=1 -> STOPPING. cpu_halt wins over stop if simultaneous.
- STOPPING: run=1, cpu_en=1 until cpu_fetch sampled high, then HALT (CPU halts on instruction boundary). cpu_halt also -> HALT.
- Presses arriving in any state other than HALT are discarded, never queued.
- Start pressed while stop_lvl=1: ignored; machine stays HALT.
- Reset mid-deposit: mem_wr_req drops asynchronously; no pc_inc issued.
- Outputs registered (Moore), no combinational paths input -> output.

Optional Feature:
Q2_PANEL_STEP_EN: adds input step_sw (raw, momentary, same debounce). In HALT a step press (priority below start, above dep) enters STEPPING: cpu_en=1, run=0, until cpu_fetch after the first one, i.e. exactly one instruction executes, then HALT. Without macro: no step_sw port, no STEPPING state.

Test Plan:
- DEBOUNCE_CYCLES=4; rst pulse then sw=12'h5A5, dep_sw 1 for 20 cycles -> mem_wr_req=1 with mem_wdata=12'h5A5 at cycle 7 after press; ack after 3 cycles -> pc_inc pulse exactly 1 cycle, then HALT.
- dep_sw glitch high for 3 cycles -> no mem_wr_req, no pc_inc.
- incp_sw pressed 3 times (each 10 cycles high, 10 low) -> exactly 3 pc_inc pulses, run=0 throughout.
- start press -> run=1, cpu_en=1; stop_sw high -> run stays 1 until cpu_fetch pulse, then run=0, cpu_en=0 next cycle; start pressed while stop high -> run stays 0.
- In RUN, cpu_halt pulse -> run=0 next cycle; dep press during RUN -> no mem_wr_req after halt.
- rst asserted in DEP_WR with ack withheld -> mem_wr_req=0 immediately, pc_inc never pulses, run=0.
